// File: rtl/inst_axi_reader.sv
// Single-beat AXI4 instruction fetch engine: turns a one-cycle cache request into
// one AR/R transaction and returns the word as a one-cycle completion pulse.
module inst_axi_reader #(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_interface_call_begin,
    input  logic [31:0] inst_interface_addr,
    output logic        inst_interface_return_ready,
    output logic [31:0] inst_interface_rdata,
    output logic        inst_interface_resp_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ADDR = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    logic [1:0]  state_r;
    logic [31:0] araddr_r;
    logic        arvalid_r;
    logic        rready_r;
    logic        return_ready_r;
    logic [31:0] rdata_r;
    logic        resp_err_r;
    logic        unused_s;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

    // rlast never gates acceptance (single-beat bursts) and the address is word-aligned.
    assign unused_s = ^{rlast, inst_interface_addr[1:0]};

    // Transaction sequencer; all protocol and cache-facing outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            araddr_r       <= 32'h0000_0000;
            arvalid_r      <= 1'b0;
            rready_r       <= 1'b0;
            return_ready_r <= 1'b0;
            rdata_r        <= 32'h0000_0000;
            resp_err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (inst_interface_call_begin) begin
                        araddr_r  <= {inst_interface_addr[31:2], 2'b00};
                        arvalid_r <= 1'b1;
                        state_r   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arvalid_r && arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Beats carrying a foreign ID are consumed and dropped.
                    if (rvalid && (rid == AXI_ID)) begin
                        rdata_r        <= rdata;
                        return_ready_r <= 1'b1;
                        resp_err_r     <= resp_is_err(rresp);
                        rready_r       <= 1'b0;
                        state_r        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    return_ready_r <= 1'b0;
                    resp_err_r     <= 1'b0;
                    rdata_r        <= 32'h0000_0000;
                    state_r        <= ST_IDLE;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    arvalid_r      <= 1'b0;
                    rready_r       <= 1'b0;
                    return_ready_r <= 1'b0;
                    rdata_r        <= 32'h0000_0000;
                    resp_err_r     <= 1'b0;
                end
            endcase
        end
    end

    assign arid                        = AXI_ID;
    assign arlen                       = 8'h00;
    assign arsize                      = 3'b010;
    assign arburst                     = 2'b01;
    assign araddr                      = araddr_r;
    assign arvalid                     = arvalid_r;
    assign rready                      = rready_r;
    assign inst_interface_return_ready = return_ready_r;
    assign inst_interface_rdata        = rdata_r;
    assign inst_interface_resp_err     = resp_err_r;

endmodule
